// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, segment codes and helpers for the BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef logic [3:0] digit_t;

    // Segment codes, bit order g,f,e,d,c,b,a with a in bit 0
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// rtl/bcd_seg_dec.sv - combinational BCD digit to 7-segment decode (10-15 blank)
module bcd_seg_dec
    import bcd_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/acc_bcd_conv.sv
// rtl/acc_bcd_conv.sv - sequential double-dabble binary to BCD converter; BCD_SEG_EN adds registered 7-seg output
module acc_bcd_conv
    import bcd_pkg::*;
#(
    parameter int IN_W = 7,
    parameter int DIG  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*DIG-1:0]  bcd,
    output logic              busy
`ifdef BCD_SEG_EN
    ,
    output logic [7*DIG-1:0]  seg
`endif
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

    if (pow10(DIG) <= (longint'(1) << IN_W) - 1) begin : g_param_chk
        $error("acc_bcd_conv: DIG too small for IN_W");
    end

    state_t            state, state_nxt;
    logic [4*DIG-1:0]  work, work_adj, work_nxt;
    logic [IN_W-1:0]   sreg, sreg_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              load;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);
    assign load      = (state == SHIFT) && (cnt == LAST);

    // Add-3 correction precedes the shift so every digit stays within 0-9 afterwards
    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIG; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        {work_nxt, sreg_nxt} = {work_adj, sreg} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            sreg <= '0;
            cnt  <= '0;
            bcd  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sreg <= bin;
                    work <= '0;
                    cnt  <= '0;
                end
                SHIFT: begin
                    work <= work_nxt;
                    sreg <= sreg_nxt;
                    cnt  <= cnt + 1'b1;
                    if (load) bcd <= work_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_SEG_EN
    logic [7*DIG-1:0] seg_nxt;

    for (genvar g = 0; g < DIG; g++) begin : g_seg
        bcd_seg_dec u_dec (
            .digit (work_nxt[4*g +: 4]),
            .seg   (seg_nxt[7*g +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)       seg <= '0;
        else if (load) seg <= seg_nxt;
    end
`endif

endmodule

// File: doc/acc_bcd_conv.md
Name: acc_bcd_conv

Overview:
Downstream stage of the ALU accumulator. Accepts the 7-bit accumulated binary value over a valid/ready handshake. Converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. Presents the result with a valid/ready handshake to the display or readout logic.

Parameters:
IN_W, 7, binary input width; equals the accumulator width.
DIG, 3, number of BCD digits; must satisfy 10^DIG > 2^IN_W-1. An elaboration-time check fails the build otherwise.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  bin is valid
in_ready  output  1  block can accept bin
bin  input  IN_W  unsigned binary value, from the accumulator output
out_valid  output  1  bcd holds a completed conversion
out_ready  input  1  consumer accepts bcd
bcd  output  4*DIG  packed BCD; digit 0 in bits [3:0]
busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, bcd=0, out_valid=0, busy=0, in_ready=1 (combinational from state), shift counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: capture bin into the shift register, clear the BCD working register, set cnt=0, go to SHIFT.
  - out_ready is ignored in this state.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge: every working digit >=5 gets +3, then the concatenation {digits, shift register} shifts left by 1. cnt increments.
  - On the edge where cnt reaches IN_W-1, the final shift is performed, bcd is loaded from the working digits, and the state moves to DONE.
- DONE:
  - out_valid=1; bcd stays stable.
  - When out_ready=1 at an edge: out_valid falls and the state goes to IDLE.
  - No new input is accepted in DONE (in_ready=0).
- Latency: input accepted at edge k means out_valid=1 after edge k+IN_W (7 cycles at default).
- Throughput: at most one conversion every IN_W+2 cycles when out_ready is held high.
- bcd register is written only on the SHIFT->DONE transition. It holds its value through IDLE until the next conversion completes.
- Arithmetic:
  - Each digit add is 4-bit, with no carry out, because a digit <=9 before the add.
  - Working digits never exceed 9 after a shift, given the parameter check.
- Boundary conditions:
  - bin=0 yields bcd=0.
  - bin=2^IN_W-1 yields full-scale (127 -> 0x127).
  - in_valid while busy or in DONE is ignored; the source must hold bin until in_ready.
  - rst asserted in SHIFT or DONE aborts: next state IDLE, bcd=0, out_valid=0.
  - rst and in_valid high together: rst wins.

Optional Feature:
BCD_SEG_EN:
- Defined:
  - Adds output port seg [7*DIG-1:0], active-high segments per digit in bit order g,f,e,d,c,b,a (a = LSB). Digit 0 occupies bits [6:0].
  - seg is registered, updates on the same edge as bcd, and resets to 0.
  - Digit codes 10-15 decode to all segments off.
- Undefined: the seg port and its decode logic are absent; everything else is identical.

Decomposition:
- Package bcd_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the 7-bit segment constants for 0-9 and blank;
  - a digit_t 4-bit typedef.
- One sub-module is natural: bcd_seg_dec, a combinational 4-bit to 7-segment decode. It is instantiated DIG times inside a BCD_SEG_EN generate region.

Test Plan:
1. rst=1 for 2 cycles, then release -> bcd=0x000, out_valid=0, in_ready=1, busy=0.
2. bin=127, in_valid pulse, out_ready=1 -> out_valid rises exactly 7 cycles after acceptance with bcd=0x127; in_ready returns 1 one cycle after the out handshake.
3. bin=0, then bin=99 back-to-back with in_valid held high -> bcd=0x000, then bcd=0x099. The second input is accepted only when in_ready=1.
4. out_ready held low for 5 cycles after a conversion of 45 -> bcd=0x045 stays stable, out_valid=1, in_ready=0; in_valid with bin=12 during the stall is ignored.
5. Start a conversion of 100 and assert rst at the 3rd SHIFT cycle -> next cycle state=IDLE, bcd=0, out_valid=0. A fresh conversion of 64 then gives 0x064.
6. With BCD_SEG_EN defined, convert 127 -> seg digit2=0x06, digit1=0x5B, digit0=0x07, aligned with out_valid.
